// File: rtl/simple_axi_slave_mem.sv
// Single-port 64-bit AXI4 memory slave, single-beat byte/half/word/dword, lane-0 justified data.
// Latency: AW->wready 1 cycle, W->bvalid 1 cycle, AR->rvalid+rdata 1 cycle (plus STALL_CYCLES per phase with SAXI_STALL_EN).
// Backpressure: one transaction at a time; bvalid/rvalid and payload held until bready/rready, write wins over read.
// Optional feature macro: SAXI_STALL_EN (per-phase wait-state counter loaded with STALL_CYCLES).
module simple_axi_slave_mem #(
  parameter int          DEPTH        = 512,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          STALL_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic [7:0]  s_axi_awlen,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic        s_axi_wlast,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic [7:0]  s_axi_arlen,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        s_axi_rlast,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp
);

  localparam int          IDXW    = $clog2(DEPTH);
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, W_DATA, W_DRAIN, W_RESP, R_DATA} state_t;

  // Malformed requests (bursts, misalignment, oversize) outrank an address miss.
  function automatic logic [1:0] decode(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln);
    logic mis;
    logic hit;
    case (sz)
      3'd0:    mis = 1'b0;
      3'd1:    mis = a[0];
      3'd2:    mis = |a[1:0];
      3'd3:    mis = |a[2:0];
      default: mis = 1'b1;
    endcase
    hit = (a >= BASE_ADDR) && ({1'b0, a} < WIN_END);
    if (ln != 8'd0 || mis)
      decode = RESP_SLVERR;
    else if (!hit)
      decode = RESP_DECERR;
    else
      decode = RESP_OKAY;
  endfunction

  // Word index inside the window; BASE_ADDR alignment makes the low bits of the offset sufficient.
  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE_ADDR;
    word_idx = IDXW'(d >> 3);
  endfunction

  function automatic logic [7:0] size_bmask(input logic [2:0] sz);
    case (sz)
      3'd0:    size_bmask = 8'h01;
      3'd1:    size_bmask = 8'h03;
      3'd2:    size_bmask = 8'h0F;
      default: size_bmask = 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] size_dmask(input logic [2:0] sz);
    logic [7:0] bm;
    bm = size_bmask(sz);
    for (int b = 0; b < 8; b++)
      size_dmask[8*b +: 8] = {8{bm[b]}};
  endfunction

  state_t          state_q, state_d;
  logic            idle_rdy_q, wready_q, bvalid_q, rvalid_q;
  logic            stall_done;
  logic [1:0]      resp_q;
  logic [2:0]      off_q, size_q;
  logic [IDXW-1:0] idx_q;
  logic            rd_ok_q;
  logic            aw_hs, ar_hs, w_hs, b_hs, r_hs;
  logic [63:0]     mem [DEPTH];
  logic [63:0]     ram_q;
  logic            ram_we, ram_re;
  logic [IDXW-1:0] ram_idx;
  logic [7:0]      ram_be;
  logic [63:0]     ram_wd;

  // In IDLE a pending AW blocks arready so the write always wins a tie.
  assign s_axi_awready = idle_rdy_q;
  assign s_axi_arready = idle_rdy_q & ~s_axi_awvalid;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = resp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rvalid_q;
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = rd_ok_q ? ((ram_q >> {off_q, 3'b000}) & size_dmask(size_q)) : 64'd0;

  assign aw_hs = s_axi_awvalid & idle_rdy_q;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign b_hs  = bvalid_q & s_axi_bready;
  assign r_hs  = rvalid_q & s_axi_rready;

  // Next-state decode for the transaction sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = W_DATA;
               else if (ar_hs) state_d = R_DATA;
      W_DATA:  if (w_hs) state_d = s_axi_wlast ? W_RESP : W_DRAIN;
      W_DRAIN: if (w_hs && s_axi_wlast) state_d = W_RESP;
      W_RESP:  if (b_hs) state_d = IDLE;
      R_DATA:  if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SAXI_STALL_EN
  localparam logic [3:0] STALL_LD = 4'(STALL_CYCLES);
  logic [3:0] stall_q, stall_d;

  // Reload on every phase change except into drain (its wait was served in W_DATA), else count down to 0.
  always_comb begin
    stall_d = (stall_q != 4'd0) ? stall_q - 4'd1 : 4'd0;
    if (state_d != state_q && state_d != W_DRAIN)
      stall_d = STALL_LD;
  end

  // Wait-state counter; reset counts as a return to IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= STALL_LD;
    else       stall_q <= stall_d;
  end

  assign stall_done = (stall_d == 4'd0);
`else
  logic [3:0] unused_stall;
  assign unused_stall = 4'(STALL_CYCLES);
  assign stall_done   = 1'b1;
`endif

  // State register and registered ready/valid outputs for the state being entered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idle_rdy_q <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_rdy_q <= (state_d == IDLE) && stall_done;
      wready_q   <= (state_d == W_DATA || state_d == W_DRAIN) && stall_done;
      bvalid_q   <= (state_d == W_RESP) && stall_done;
      rvalid_q   <= (state_d == R_DATA) && stall_done;
    end
  end

  // Capture decoded request attributes at the address handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      resp_q  <= RESP_OKAY;
      off_q   <= 3'd0;
      size_q  <= 3'd0;
      idx_q   <= '0;
      rd_ok_q <= 1'b0;
    end else if (aw_hs) begin
      resp_q  <= decode(s_axi_awaddr, s_axi_awsize, s_axi_awlen);
      off_q   <= s_axi_awaddr[2:0];
      size_q  <= s_axi_awsize;
      idx_q   <= word_idx(s_axi_awaddr);
    end else if (ar_hs) begin
      resp_q  <= decode(s_axi_araddr, s_axi_arsize, s_axi_arlen);
      off_q   <= s_axi_araddr[2:0];
      size_q  <= s_axi_arsize;
      rd_ok_q <= (decode(s_axi_araddr, s_axi_arsize, s_axi_arlen) == RESP_OKAY);
    end
  end

  // Reads use the live AR address so data is ready the cycle after the handshake.
  assign ram_re  = ar_hs;
  assign ram_we  = (state_q == W_DATA) && w_hs && (resp_q == RESP_OKAY);
  assign ram_idx = (state_q == IDLE) ? word_idx(s_axi_araddr) : idx_q;
  assign ram_be  = 8'((s_axi_wstrb & size_bmask(size_q)) << off_q);
  assign ram_wd  = s_axi_wdata << {off_q, 3'b000};

  // Single-port byte-enable RAM with synchronous read; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int b = 0; b < 8; b++)
        if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wd[8*b +: 8];
    end
    if (ram_re)
      ram_q <= mem[ram_idx];
  end

endmodule
